relogio_hms: RTL and testbench

RELOGIO_HMS -- requirements
Module: relogio_hms

---
 rtl/relogio_hms.sv | 204 ++++++++++++++++++++
 tb/tb_relogio_hms.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/relogio_hms.sv
// ---------------------------------------------------------------------------
// relogio_hms -- BCD hours:minutes:seconds clock with a three-mode setter.
//
// Ports
//   clk_in    system clock (50 MHz)
//   rst       asynchronous active-low reset; release is synchronised to clk_in
//   clk_1hz   1 Hz square wave, already registered in the clk_in domain
//   btn_modo  one-cycle pulse: RUN -> SET_HORA -> SET_MIN -> RUN
//   btn_inc   one-cycle pulse: increment the field selected by the mode
//   hora_d/hora_u, min_d/min_u, seg_d/seg_u   BCD tens/units digits
//   modo      00 RUN, 01 SET_HORA, 10 SET_MIN
//   pm        PM flag (only meaningful in 12h mode, otherwise tied to 0)
//
// Configuration
//   RELOGIO_MODO_12H_EN  defined   -> hours count 12,01..11,12; pm toggles
//                                     on every 11->12 step; reset 12:00:00
//                        undefined -> hours count 00..23, pm = 0
// ---------------------------------------------------------------------------
module relogio_hms (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       clk_1hz,
    input  logic       btn_modo,
    input  logic       btn_inc,
    output logic [3:0] hora_d,
    output logic [3:0] hora_u,
    output logic [3:0] min_d,
    output logic [3:0] min_u,
    output logic [3:0] seg_d,
    output logic [3:0] seg_u,
    output logic [1:0] modo,
    output logic       pm
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HORA = 2'b01,
        SET_MIN  = 2'b10
    } modo_e;

`ifdef RELOGIO_MODO_12H_EN
    localparam logic [3:0] HR_RST_T = 4'd1;
    localparam logic [3:0] HR_RST_U = 4'd2;
`else
    localparam logic [3:0] HR_RST_T = 4'd0;
    localparam logic [3:0] HR_RST_U = 4'd0;
`endif

    // Reset: asserts immediately, deasserts two clk_in edges after rst rises.
    logic rst_meta_q, rst_sync_q;
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    logic rst_n_int;
    assign rst_n_int = rst_sync_q;

    // Seconds/minutes increment: returns {carry, tens, units}.
    function automatic logic [8:0] inc60(input logic [3:0] t, input logic [3:0] u);
        logic [8:0] r;
        if (u == 4'd9) begin
            if (t == 4'd5) r = {1'b1, 4'd0, 4'd0};
            else           r = {1'b0, t + 4'd1, 4'd0};
        end else begin
            r = {1'b0, t, u + 4'd1};
        end
        return r;
    endfunction

    // Hour increment with wrap, returns {tens, units}.
    function automatic logic [7:0] inc_hour(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] r;
`ifdef RELOGIO_MODO_12H_EN
        if (t == 4'd1 && u == 4'd2) r = {4'd0, 4'd1};
`else
        if (t == 4'd2 && u == 4'd3) r = {4'd0, 4'd0};
`endif
        else if (u == 4'd9)         r = {t + 4'd1, 4'd0};
        else                        r = {t, u + 4'd1};
        return r;
    endfunction

    modo_e      modo_q, modo_d;
    logic [3:0] hr_t_q, hr_u_q, mn_t_q, mn_u_q, sc_t_q, sc_u_q;
    logic [3:0] hr_t_d, hr_u_d, mn_t_d, mn_u_d, sc_t_d, sc_u_d;
    logic       clk_1hz_q;
    logic       armed_q;    // blocks a tick on the first cycle out of reset
    logic       tick;
    logic [8:0] sc_inc, mn_inc;
    logic [7:0] hr_inc;
`ifdef RELOGIO_MODO_12H_EN
    logic       pm_q, pm_d;
    logic       hr_is_11;
    assign hr_is_11 = (hr_t_q == 4'd1) && (hr_u_q == 4'd1);
`endif

    // clk_1hz_q follows clk_1hz in every mode so leaving SET never fakes an edge.
    assign tick   = clk_1hz & ~clk_1hz_q & armed_q;
    assign sc_inc = inc60(sc_t_q, sc_u_q);
    assign mn_inc = inc60(mn_t_q, mn_u_q);
    assign hr_inc = inc_hour(hr_t_q, hr_u_q);

    always_comb begin
        modo_d = modo_q;
        hr_t_d = hr_t_q;
        hr_u_d = hr_u_q;
        mn_t_d = mn_t_q;
        mn_u_d = mn_u_q;
        sc_t_d = sc_t_q;
        sc_u_d = sc_u_q;
`ifdef RELOGIO_MODO_12H_EN
        pm_d   = pm_q;
`endif
        // btn_modo wins over both tick and btn_inc in the same cycle.
        case (modo_q)
            RUN: begin
                if (btn_modo) begin
                    modo_d = SET_HORA;
                end else if (tick) begin
                    {sc_t_d, sc_u_d} = sc_inc[7:0];
                    if (sc_inc[8]) begin
                        {mn_t_d, mn_u_d} = mn_inc[7:0];
                        if (mn_inc[8]) begin
                            {hr_t_d, hr_u_d} = hr_inc;
`ifdef RELOGIO_MODO_12H_EN
                            if (hr_is_11) pm_d = ~pm_q;
`endif
                        end
                    end
                end
            end
            SET_HORA: begin
                if (btn_modo) begin
                    modo_d = SET_MIN;
                end else if (btn_inc) begin
                    {hr_t_d, hr_u_d} = hr_inc;
`ifdef RELOGIO_MODO_12H_EN
                    if (hr_is_11) pm_d = ~pm_q;
`endif
                end
            end
            SET_MIN: begin
                if (btn_modo) begin
                    modo_d = RUN;
                    sc_t_d = 4'd0;
                    sc_u_d = 4'd0;
                end else if (btn_inc) begin
                    // minutes wrap on their own: no carry into hours
                    {mn_t_d, mn_u_d} = mn_inc[7:0];
                end
            end
            default: modo_d = RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_int) begin
        if (!rst_n_int) begin
            modo_q    <= RUN;
            hr_t_q    <= HR_RST_T;
            hr_u_q    <= HR_RST_U;
            mn_t_q    <= 4'd0;
            mn_u_q    <= 4'd0;
            sc_t_q    <= 4'd0;
            sc_u_q    <= 4'd0;
            clk_1hz_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            modo_q    <= modo_d;
            hr_t_q    <= hr_t_d;
            hr_u_q    <= hr_u_d;
            mn_t_q    <= mn_t_d;
            mn_u_q    <= mn_u_d;
            sc_t_q    <= sc_t_d;
            sc_u_q    <= sc_u_d;
            clk_1hz_q <= clk_1hz;
            armed_q   <= 1'b1;
        end
    end

`ifdef RELOGIO_MODO_12H_EN
    always_ff @(posedge clk_in or negedge rst_n_int) begin
        if (!rst_n_int) pm_q <= 1'b0;
        else            pm_q <= pm_d;
    end
    assign pm = pm_q;
`else
    assign pm = 1'b0;
`endif

    assign hora_d = hr_t_q;
    assign hora_u = hr_u_q;
    assign min_d  = mn_t_q;
    assign min_u  = mn_u_q;
    assign seg_d  = sc_t_q;
    assign seg_u  = sc_u_q;
    assign modo   = modo_q;

endmodule

// File: tb/tb_relogio_hms.sv
// ---------------------------------------------------------------------------
// tb_relogio_hms -- self-checking bench for relogio_hms.
// Reference model keeps hours/minutes/seconds as plain integers and derives
// the expected BCD digits with / and %.
// ---------------------------------------------------------------------------
module tb_relogio_hms;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       clk_1hz = 1'b0;
    logic       btn_modo = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] hora_d, hora_u, min_d, min_u, seg_d, seg_u;
    logic [1:0] modo;
    logic       pm;

    bit clk_run = 1'b1;
    int checks = 0;
    int errors = 0;

    // reference model state
    int h, m, s, md, pmv;
    bit prev;

    relogio_hms dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .clk_1hz  (clk_1hz),
        .btn_modo (btn_modo),
        .btn_inc  (btn_inc),
        .hora_d   (hora_d),
        .hora_u   (hora_u),
        .min_d    (min_d),
        .min_u    (min_u),
        .seg_d    (seg_d),
        .seg_u    (seg_u),
        .modo     (modo),
        .pm       (pm)
    );

    always begin
        #10;
        if (clk_run) clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".hora_d"}, hora_d, h / 10);
        chk({tag, ".hora_u"}, hora_u, h % 10);
        chk({tag, ".min_d"},  min_d,  m / 10);
        chk({tag, ".min_u"},  min_u,  m % 10);
        chk({tag, ".seg_d"},  seg_d,  s / 10);
        chk({tag, ".seg_u"},  seg_u,  s % 10);
        chk({tag, ".modo"},   modo,   md);
        chk({tag, ".pm"},     pm,     pmv);
    endtask

    task automatic model_hour_inc();
`ifdef RELOGIO_MODO_12H_EN
        if (h == 12) h = 1;
        else begin
            h = h + 1;
            if (h == 12) pmv = 1 - pmv;
        end
`else
        h = (h + 1) % 24;
`endif
    endtask

    task automatic model_reset(input bit c);
`ifdef RELOGIO_MODO_12H_EN
        h = 12;
`else
        h = 0;
`endif
        m = 0; s = 0; md = 0; pmv = 0; prev = c;
    endtask

    // One clk_in cycle: drive inputs, advance model at the edge, compare after.
    task automatic step(input bit bm, input bit bi, input bit c);
        bit tk;
        btn_modo = bm; btn_inc = bi; clk_1hz = c;
        @(posedge clk_in);
        tk = c && !prev;
        prev = c;
        case (md)
            0: if (bm) md = 1;
               else if (tk) begin
                   s++;
                   if (s == 60) begin
                       s = 0; m++;
                       if (m == 60) begin m = 0; model_hour_inc(); end
                   end
               end
            1: if (bm) md = 2;
               else if (bi) model_hour_inc();
            default: if (bm) begin md = 0; s = 0; end
                     else if (bi) m = (m + 1) % 60;
        endcase
        #1;
        check_all("step");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0);
            step(0, 0, 1);
        end
        step(0, 0, 0);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end
    endtask

    task automatic do_reset(input bit c, input bit stop_clk);
        btn_modo = 0; btn_inc = 0; clk_1hz = c;
        if (stop_clk) clk_run = 1'b0;
        rst = 1'b0;
        #3;
        model_reset(c);
        check_all("rst");
        clk_run = 1'b1;
        @(negedge clk_in);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 0, c);
    endtask

    int flat;
    bit rc;

    initial begin
        // Reset with clk_1hz held high: release must not yield a tick.
        do_reset(1'b1, 1'b0);
        chk("no_tick_after_release", {seg_d, seg_u}, 0);

        // 60 rising edges of clk_1hz from reset -> 00:01:00
        ticks(60);
        chk("sixty_ticks.min", m, 1);
        chk("sixty_ticks.dut_min_u", min_u, 1);
        chk("sixty_ticks.dut_seg", {seg_d, seg_u}, 0);

        // Preload 23:59 via SET, run to 23:59:59, one tick -> midnight
        do_reset(1'b0, 1'b0);
        step(1, 0, 0);
        incs(23);
        step(1, 0, 0);
        incs(59);
        step(1, 0, 0);
        ticks(59);
`ifndef RELOGIO_MODO_12H_EN
        flat = {hora_d, hora_u, min_d, min_u, seg_d, seg_u};
        chk("pre_midnight", flat, 24'h235959);
        step(0, 0, 1);
        flat = {hora_d, hora_u, min_d, min_u, seg_d, seg_u};
        chk("midnight_wrap", flat, 24'h000000);
`else
        step(0, 0, 1);
`endif
        step(0, 0, 0);

        // SET sequence with ticks during SET -> 05:01:00
        do_reset(1'b0, 1'b0);
        ticks(7);
        step(1, 0, 0);
        incs(5);
        ticks(3);
        step(1, 0, 0);
        incs(61);
        ticks(4);
        step(1, 0, 0);
`ifndef RELOGIO_MODO_12H_EN
        flat = {hora_d, hora_u, min_d, min_u, seg_d, seg_u};
        chk("set_seq", flat, 24'h050100);
`endif
        chk("set_seq.modo", modo, 0);

        // btn_modo and btn_inc together in RUN: mode only
        step(1, 1, 0);
        chk("modo_inc_same.modo", modo, 1);
        chk("modo_inc_same.hora", {hora_d, hora_u}, {h / 10, h % 10} == 0 ? 0 : (h / 10) * 16 + h % 10);
        step(1, 0, 0);
        step(1, 0, 0);

        // btn_modo coincident with a tick in RUN drops the tick
        step(0, 0, 0);
        step(1, 0, 1);
        chk("modo_tick_same.modo", modo, 1);
        step(1, 0, 1);
        step(1, 0, 0);

        // Randomised run
        rc = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) rc = ~rc;
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0, rc);
        end

        // Reset asserted mid-SET_MIN with the clock stopped
        do_reset(1'b0, 1'b0);
        step(1, 0, 0);
        incs(3);
        step(1, 0, 0);
        incs(7);
        chk("pre_rst_mid.modo", modo, 2);
        do_reset(1'b0, 1'b1);
        chk("rst_mid_set.min", {min_d, min_u}, 0);
        chk("rst_mid_set.modo", modo, 0);

`ifdef RELOGIO_MODO_12H_EN
        // 11:59:59 -> 12:00:00 pm=1, then 12:59:59 -> 01:00:00 pm unchanged
        step(1, 0, 0);
        incs(11);
        step(1, 0, 0);
        incs(59);
        step(1, 0, 0);
        ticks(60);
        chk("pm_toggle", pm, 1);
        ticks(3600);
        chk("pm_hold", pm, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
